// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control/status bundle between the multi-cycle controller and its datapath
//
// Purpose: groups the IR fields and datapath flags that the controller reads
// with the mux selects and write enables that it drives.
// Modports:
//   master - controller side: reads opcode/funct3/funct7/Zero/Lt/mem_ready,
//            drives PCWrite/IRWrite/AdrSrc/MemWrite/RegWrite/ResultSrc/
//            ALUSrcA/ALUSrcB/ImmSrc/ALUControl/instr_done/illegal
//   slave  - datapath side: the mirror image of master
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       Lt;
  logic       mem_ready;

  logic       PCWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, funct3, funct7, Zero, Lt, mem_ready,
    output PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_done, illegal
  );

  modport slave (
    output opcode, funct3, funct7, Zero, Lt, mem_ready,
    input  PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - state sequencer for the shared multi-cycle RV32I datapath
//
// Purpose: walks each instruction through FETCH/DECODE/... states, steering the
// datapath muxes and pulsing its write enables; traps unsupported encodings in
// a sticky ILLEGAL state that only reset leaves.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset; also gates all write enables low
//            combinationally while asserted
//   bus    - multicycle_controller_if.master (IR fields, ALU flags,
//            mem_ready in; mux selects, write enables, instr_done, illegal out)
module multicycle_controller (
  input  logic                          clk,
  input  logic                          rst_n,
  multicycle_controller_if.master       bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK,
    S_LUI, S_ILLEGAL
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [2:0] w_imm_src;
  logic [2:0] w_alu_control;
  logic       w_branch_taken;
  logic       w_shift_op;
  logic       w_unused_funct7;

  // Only funct7[5] (SUB vs ADD) matters to this controller.
  assign w_unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

  // Shift encodings (funct3 001/101) are decoded to the ILLEGAL state.
  assign w_shift_op = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b101);

  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_decode = sub ? ALU_SUB : ALU_ADD;
      3'b111:  alu_decode = ALU_AND;
      3'b110:  alu_decode = ALU_OR;
      3'b100:  alu_decode = ALU_XOR;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

  always_comb begin
    case (bus.funct3)
      3'b000:  w_branch_taken = bus.Zero;
      3'b001:  w_branch_taken = !bus.Zero;
      3'b100:  w_branch_taken = bus.Lt;
      3'b101:  w_branch_taken = !bus.Lt;
      default: w_branch_taken = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = w_shift_op ? S_ILLEGAL : S_EXEC_R;
          OP_I:              w_next = w_shift_op ? S_ILLEGAL : S_EXEC_I;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          default:           w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   w_next = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXEC_R:   w_next = S_ALUWB;
      S_EXEC_I:   w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_JALR:     w_next = S_LINK;
      S_LINK:     w_next = S_FETCH;
      S_LUI:      w_next = S_FETCH;
      S_ILLEGAL:  w_next = S_ILLEGAL;
      default:    w_next = S_ILLEGAL;
    endcase
  end

  // Output logic
  always_comb begin
    w_pc_write    = 1'b0;
    w_ir_write    = 1'b0;
    w_adr_src     = 1'b0;
    w_mem_write   = 1'b0;
    w_reg_write   = 1'b0;
    w_result_src  = 2'b00;
    w_alu_src_a   = 2'b00;
    w_alu_src_b   = 2'b00;
    w_imm_src     = IMM_I;
    w_alu_control = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = bus.mem_ready;
        w_pc_write   = bus.mem_ready;
      end
      S_DECODE: begin
        // OldPC + imm precomputes the branch/jump target into ALUOut.
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        w_imm_src   = (bus.opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_imm_src   = (bus.opcode == OP_LOAD) ? IMM_I : IMM_S;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXEC_R: begin
        w_alu_src_a   = 2'b10;
        w_alu_control = alu_decode(bus.funct3, bus.funct7[5]);
      end
      S_EXEC_I: begin
        w_alu_src_a   = 2'b10;
        w_alu_src_b   = 2'b01;
        w_alu_control = alu_decode(bus.funct3, 1'b0);
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a   = 2'b10;
        w_alu_control = ALU_SUB;
        w_pc_write    = w_branch_taken;
      end
      S_JAL: begin
        w_pc_write  = 1'b1;
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
      end
      S_JALR: begin
        w_alu_src_a  = 2'b10;
        w_alu_src_b  = 2'b01;
        w_result_src = 2'b10;
        w_pc_write   = 1'b1;
      end
      S_LINK: begin
        w_alu_src_a  = 2'b01;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_reg_write  = 1'b1;
      end
      S_LUI: begin
        w_imm_src    = IMM_U;
        w_result_src = 2'b11;
        w_reg_write  = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are masked by reset so an aborted instruction stops writing
  // in the same cycle reset is asserted, not one edge later.
  assign bus.PCWrite    = w_pc_write  & rst_n;
  assign bus.IRWrite    = w_ir_write  & rst_n;
  assign bus.MemWrite   = w_mem_write & rst_n;
  assign bus.RegWrite   = w_reg_write & rst_n;
  assign bus.AdrSrc     = w_adr_src;
  assign bus.ResultSrc  = w_result_src;
  assign bus.ALUSrcA    = w_alu_src_a;
  assign bus.ALUSrcB    = w_alu_src_b;
  assign bus.ImmSrc     = w_imm_src;
  assign bus.ALUControl = w_alu_control;
  // FETCH waiting on memory also loops to FETCH but is not an instruction end.
  assign bus.instr_done = rst_n && (w_next == S_FETCH) &&
                          (r_state != S_FETCH) && (r_state != S_ILLEGAL);
  assign bus.illegal    = (r_state == S_ILLEGAL);

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pcw;
    logic       irw;
    logic       adr;
    logic       memw;
    logic       regw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] imm;
    logic [2:0] alu;
    logic       done;
    logic       ill;
  } outs_t;

  // Instruction phases as listed in the controller's operation table.
  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, ER = 6, EI = 7,
                 AWB = 8, BR = 9, J = 10, JR = 11, LK = 12, LU = 13, ILL = 14;

  int n_vec = 0;
  int n_err = 0;
  int instr_idx = 0;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic [6:0] cur_f7;

  logic mr_q[$];
  int   zl_fixed = 0;
  logic z_fix, lt_fix;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  function automatic string step_name(input int st);
    case (st)
      F: return "FETCH";    D: return "DECODE";  MA: return "MEMADR";
      MR: return "MEMREAD"; MWB: return "MEMWB"; MW: return "MEMWRITE";
      ER: return "EXEC_R";  EI: return "EXEC_I"; AWB: return "ALUWB";
      BR: return "BRANCH";  J: return "JAL";     JR: return "JALR";
      LK: return "LINK";    LU: return "LUI";    default: return "ILLEGAL";
    endcase
  endfunction

  // ALU code the ISA assigns to an arithmetic funct3 (SUB only for R-type f7[5]).
  function automatic logic [2:0] alu_for(input logic [2:0] f3, input logic sub);
    logic [2:0] tbl [8];
    tbl = '{3'd0, 3'd0, 3'd5, 3'd6, 3'd4, 3'd0, 3'd3, 3'd2};
    return (f3 == 3'd0 && sub) ? 3'd1 : tbl[f3];
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z, input logic lt);
    if (f3 == 3'd0) return z;
    if (f3 == 3'd1) return !z;
    if (f3 == 3'd4) return lt;
    if (f3 == 3'd5) return !lt;
    return 1'b0;
  endfunction

  function automatic outs_t expect_out(input int st, input logic mr, input logic z, input logic lt);
    outs_t e;
    e = '0;
    case (st)
      F:   begin e.irw = mr; e.pcw = mr; e.sb = 2'd2; e.res = 2'd2; end
      D:   begin e.sa = 2'd1; e.sb = 2'd1; e.imm = (cur_op == 7'b1101111) ? 3'd3 : 3'd2; end
      MA:  begin e.sa = 2'd2; e.sb = 2'd1; e.imm = (cur_op == 7'b0000011) ? 3'd0 : 3'd1; end
      MR:  begin e.adr = 1'b1; end
      MWB: begin e.res = 2'd1; e.regw = 1'b1; e.done = 1'b1; end
      MW:  begin e.adr = 1'b1; e.memw = 1'b1; e.done = mr; end
      ER:  begin e.sa = 2'd2; e.alu = alu_for(cur_f3, cur_f7[5]); end
      EI:  begin e.sa = 2'd2; e.sb = 2'd1; e.alu = alu_for(cur_f3, 1'b0); end
      AWB: begin e.regw = 1'b1; e.done = 1'b1; end
      BR:  begin e.sa = 2'd2; e.alu = 3'd1; e.pcw = taken(cur_f3, z, lt); e.done = 1'b1; end
      J:   begin e.pcw = 1'b1; e.sa = 2'd1; e.sb = 2'd2; end
      JR:  begin e.sa = 2'd2; e.sb = 2'd1; e.res = 2'd2; e.pcw = 1'b1; end
      LK:  begin e.sa = 2'd1; e.sb = 2'd2; e.res = 2'd2; e.regw = 1'b1; e.done = 1'b1; end
      LU:  begin e.imm = 3'd4; e.res = 2'd3; e.regw = 1'b1; e.done = 1'b1; end
      default: begin e.ill = 1'b1; end
    endcase
    if (!rst_n) begin
      e.pcw = 0; e.irw = 0; e.memw = 0; e.regw = 0; e.done = 0;
    end
    return e;
  endfunction

  function automatic outs_t observed();
    outs_t o;
    o.pcw = bus.PCWrite;   o.irw = bus.IRWrite;   o.adr = bus.AdrSrc;
    o.memw = bus.MemWrite; o.regw = bus.RegWrite; o.res = bus.ResultSrc;
    o.sa = bus.ALUSrcA;    o.sb = bus.ALUSrcB;    o.imm = bus.ImmSrc;
    o.alu = bus.ALUControl; o.done = bus.instr_done; o.ill = bus.illegal;
    return o;
  endfunction

  // Entered #1 after a rising edge; drives inputs, checks at the falling edge,
  // returns #1 after the next rising edge. adv=0 means the phase is still waiting.
  task automatic do_cycle(input int st, input int stalls, output logic adv);
    logic mr, z, lt;
    outs_t e;
    if (mr_q.size() > 0) mr = mr_q.pop_front();
    else if (stalls >= 3) mr = 1'b1;
    else mr = ($urandom_range(0, 2) != 0);
    z  = zl_fixed != 0 ? z_fix  : 1'($urandom_range(0, 1));
    lt = zl_fixed != 0 ? lt_fix : 1'($urandom_range(0, 1));
    bus.mem_ready = mr;
    bus.Zero = z;
    bus.Lt = lt;
    #4;
    e = expect_out(st, mr, z, lt);
    check($sformatf("i%0d %s", instr_idx, step_name(st)), 32'(observed()), 32'(e));
    @(posedge clk);
    #1;
    adv = !((st == F) || (st == MR) || (st == MW)) || mr;
  endtask

  task automatic run_steps(input int steps[$]);
    logic adv;
    foreach (steps[k]) begin
      int stalls = 0;
      do begin
        do_cycle(steps[k], stalls, adv);
        stalls++;
      end while (!adv && stalls < 10);
      if (!adv) begin
        n_vec++; n_err++;
        $display("FAIL i%0d %s stall bound exceeded", instr_idx, step_name(steps[k]));
      end
    end
  endtask

  // kind: 0 load, 1 store, 2 R, 3 I, 4 branch, 5 jal, 6 jalr, 7 lui
  task automatic run_instr(input int kind, input logic [2:0] f3, input logic [6:0] f7);
    int steps[$];
    logic [6:0] ops [8];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    instr_idx++;
    cur_op = ops[kind]; cur_f3 = f3; cur_f7 = f7;
    bus.opcode = cur_op; bus.funct3 = f3; bus.funct7 = f7;
    case (kind)
      0: steps = '{F, D, MA, MR, MWB};
      1: steps = '{F, D, MA, MW};
      2: steps = '{F, D, ER, AWB};
      3: steps = '{F, D, EI, AWB};
      4: steps = '{F, D, BR};
      5: steps = '{F, D, J, AWB};
      6: steps = '{F, D, JR, LK};
      default: steps = '{F, D, LU};
    endcase
    run_steps(steps);
  endtask

  function automatic logic [2:0] legal_alu_f3();
    logic [2:0] pick [6];
    pick = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    return pick[$urandom_range(0, 5)];
  endfunction

  task automatic reset_cycle();
    logic adv;
    rst_n = 1'b0;
    do_cycle(ILL, 0, adv);
    rst_n = 1'b1;
  endtask

  task automatic run_illegal(input logic [6:0] op, input logic [2:0] f3);
    int steps[$];
    instr_idx++;
    cur_op = op; cur_f3 = f3; cur_f7 = 7'($urandom);
    bus.opcode = op; bus.funct3 = f3; bus.funct7 = cur_f7;
    steps = '{F, D};
    for (int k = 0; k < 20; k++) steps.push_back(ILL);
    run_steps(steps);
    reset_cycle();
  endtask

  initial begin
    logic adv;
    int kind;
    logic [6:0] bad_op;
    rst_n = 1'b0;
    bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0;
    bus.mem_ready = 1'b1; bus.Zero = 1'b0; bus.Lt = 1'b0;
    @(posedge clk);
    #1;
    do_cycle(F, 0, adv);
    rst_n = 1'b1;

    // add, sub, then lw with two memory wait cycles in MEMREAD
    mr_q = '{1, 1, 1, 1};
    run_instr(2, 3'd0, 7'h00);
    mr_q = '{1, 1, 1, 1};
    run_instr(2, 3'd0, 7'h20);
    mr_q = '{1, 1, 1, 0, 0, 1, 1};
    run_instr(0, 3'd2, 7'h00);

    // beq/bne with Zero=1, blt/bge with Lt=1
    zl_fixed = 1; z_fix = 1'b1; lt_fix = 1'b1;
    run_instr(4, 3'd0, 7'h00);
    run_instr(4, 3'd1, 7'h00);
    run_instr(4, 3'd4, 7'h00);
    run_instr(4, 3'd5, 7'h00);
    zl_fixed = 0;

    run_instr(5, 3'd0, 7'h00);
    run_instr(6, 3'd0, 7'h00);
    run_instr(7, 3'd0, 7'h00);

    run_illegal(7'b0000000, 3'd0);
    run_illegal(7'b0110011, 3'd1);
    run_illegal(7'b0010011, 3'd5);

    // Reset dropped in MEMWRITE while memory is stalling
    instr_idx++;
    cur_op = 7'b0100011; cur_f3 = 3'd2; cur_f7 = 7'h00;
    bus.opcode = cur_op; bus.funct3 = cur_f3; bus.funct7 = cur_f7;
    mr_q = '{1, 1, 1, 0};
    run_steps('{F, D, MA});
    do_cycle(MW, 0, adv);
    rst_n = 1'b0;
    do_cycle(MW, 0, adv);
    rst_n = 1'b1;
    run_instr(1, 3'd2, 7'h00);

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 8);
      case (kind)
        2, 3:    run_instr(kind, legal_alu_f3(), 7'($urandom));
        8: begin
          bad_op = 7'($urandom);
          if (bad_op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                             7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111})
            bad_op = 7'b1111111;
          run_illegal(bad_op, 3'($urandom));
        end
        default: run_instr(kind, 3'($urandom), 7'($urandom));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
